video_timing_gen: RTL
=====================

Name: video_timing_gen

Overview:
Synthesizable raster timing source that generates vsync/hsync/de for the pixel-stream path. Sits directly upstream of the PPM file read model, driving its i_vsync/i_hsync/i_de inputs.
- Sync pulses are active-high, so the frame's active region follows the falling edge of vsync.
- Defaults produce a 320x240 active raster matching the 24bpp test image.

Parameters:
H_ACTIVE, 320, active pixels per line
H_FP, 8, horizontal front porch (clocks)
H_SYNC, 16, hsync pulse width (clocks)
H_BP, 16, horizontal back porch (clocks)
V_ACTIVE, 240, active lines per frame
V_FP, 2, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BP, 4, vertical back porch (lines)
NUM_FRAMES, 1, frame limit (used only with optional feature)

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
i_en  input  1  run request, level-sensitive
o_vsync  output  1  vertical sync, active-high
o_hsync  output  1  horizontal sync, active-high
o_de  output  1  active-pixel enable
o_hpos  output  16  active pixel x; 0 when o_de=0
o_vpos  output  16  active line y; 0 when o_de=0
o_frame_start  output  1  one-cycle pulse at start of each frame
o_frame_cnt  output  16  completed-frame count, wraps at 65535->0
o_done  output  1  frame limit reached (optional feature)

Behaviour:
Reset and interface
- Reset: rst_n is asynchronous, active-low; clock is clk.
- All outputs reset to 0. FSM resets to IDLE. Counters reset to 0.

Totals and counters
- H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP (default 360).
- V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP (default 248).
- Line order within h_cnt: SYNC, BP, ACTIVE, FP. Frame order within v_cnt: same.
- Internal counters: h_cnt 0..H_TOTAL-1, v_cnt 0..V_TOTAL-1, both 16-bit.
- h_cnt wraps to 0 and increments v_cnt. v_cnt wraps to 0 at the end of the frame.

Decode (registered; outputs lag the counter state by exactly 1 clk)
- hsync = h_cnt < H_SYNC.
- vsync = v_cnt < V_SYNC, for whole lines.
- de = h in [H_SYNC+H_BP, H_SYNC+H_BP+H_ACTIVE-1] AND v in [V_SYNC+V_BP, V_SYNC+V_BP+V_ACTIVE-1].
- hpos = h_cnt - (H_SYNC+H_BP) and vpos = v_cnt - (V_SYNC+V_BP) when de; else 0.
- frame_start = (h_cnt==0 && v_cnt==0) while in RUN.

FSM (IDLE, RUN, STOP)
- IDLE:
  - Counters held at 0; outputs 0.
  - i_en=1 -> RUN. The first RUN cycle has counter (0,0), so o_vsync/o_hsync/o_frame_start rise one clk later.
- RUN:
  - Counters advance every clk.
  - At the last counter position of a frame (H_TOTAL-1, V_TOTAL-1): o_frame_cnt increments.
  - At that position, if i_en=0 -> IDLE. Otherwise wrap and continue.
  - Deasserting i_en mid-frame never truncates a frame; the stop is frame-aligned.
- STOP: only with the optional feature. Terminal until reset.
- i_en toggling while in IDLE for one cycle starts a full frame.
- Async reset mid-frame: all outputs drop to 0 immediately and the FSM goes to IDLE.
- Sum of DE cycles per frame is exactly H_ACTIVE*V_ACTIVE (default 76800).

Optional Feature:
Macro VTG_FRAME_LIMIT_EN.
- Defined:
  - When o_frame_cnt reaches NUM_FRAMES at the end of a frame, FSM -> STOP.
  - In STOP, all sync/de outputs are 0 and o_done=1, held until reset; i_en is ignored.
- Not defined:
  - Block free-runs while i_en=1.
  - STOP is unreachable; o_done is tied 0; NUM_FRAMES is unused.

Test Plan:
1. Reset asserted, then released with i_en=0 for 100 clk -> all outputs 0, o_frame_cnt=0.
2. i_en=1, defaults, run one frame:
   - o_hsync high 16 clk of every 360.
   - o_vsync high for 720 clk.
   - o_de high 76800 clk total, 320 consecutive clk per line on 240 lines.
   - First o_de occurs 6*360+32+1 clk after entering RUN.
   - o_frame_start pulses once; o_frame_cnt=1 after the frame.
3. Check o_hpos/o_vpos -> first de pixel (0,0), last (319,239); both are 0 outside de.
4. Drop i_en at line 100 of frame 2 -> frame 2 completes fully (o_frame_cnt=2), then outputs stay 0 and no further o_frame_start.
5. Pulse rst_n low mid-active-line -> o_de/o_hsync/o_vsync go 0 asynchronously. After release with i_en=1, a new frame starts from (0,0).
6. VTG_FRAME_LIMIT_EN, NUM_FRAMES=2, i_en held 1 -> exactly 2 frames are generated, then o_done=1 and sync/de stay 0 for 1000 further clk.

Source files
------------

// File: rtl/video_timing_gen.sv
// Raster timing source: vsync/hsync/de plus active-pixel coordinates for the pixel-stream path.
// Optional frame limit (stop after NUM_FRAMES frames, raise o_done) enabled by `define VTG_FRAME_LIMIT_EN.
//
// state | meaning
// IDLE  | counters held at (0,0), all outputs 0, waiting for i_en
// RUN   | counters advance each clk, decode registered onto outputs
// STOP  | frame limit reached, outputs 0 except o_done, left only by reset

module video_timing_gen #(
  parameter int unsigned H_ACTIVE   = 320,
  parameter int unsigned H_FP       = 8,
  parameter int unsigned H_SYNC     = 16,
  parameter int unsigned H_BP       = 16,
  parameter int unsigned V_ACTIVE   = 240,
  parameter int unsigned V_FP       = 2,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BP       = 4,
  parameter int unsigned NUM_FRAMES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_en,
  output logic        o_vsync,
  output logic        o_hsync,
  output logic        o_de,
  output logic [15:0] o_hpos,
  output logic [15:0] o_vpos,
  output logic        o_frame_start,
  output logic [15:0] o_frame_cnt,
  output logic        o_done
);

  localparam logic [15:0] H_LAST     = 16'(H_SYNC + H_BP + H_ACTIVE + H_FP - 1);
  localparam logic [15:0] V_LAST     = 16'(V_SYNC + V_BP + V_ACTIVE + V_FP - 1);
  localparam logic [15:0] H_SYNC_W   = 16'(H_SYNC);
  localparam logic [15:0] V_SYNC_W   = 16'(V_SYNC);
  localparam logic [15:0] H_DE_START = 16'(H_SYNC + H_BP);
  localparam logic [15:0] H_DE_END   = 16'(H_SYNC + H_BP + H_ACTIVE - 1);
  localparam logic [15:0] V_DE_START = 16'(V_SYNC + V_BP);
  localparam logic [15:0] V_DE_END   = 16'(V_SYNC + V_BP + V_ACTIVE - 1);
  localparam logic [15:0] NUM_FRAMES_W = 16'(NUM_FRAMES);

`ifdef VTG_FRAME_LIMIT_EN
  localparam bit LIMIT_EN = 1'b1;
`else
  localparam bit LIMIT_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_STOP = 2'd2
  } state_t;

  state_t      state_q;
  logic [15:0] h_cnt_q, v_cnt_q, frame_cnt_q;
  logic        vsync_q, hsync_q, de_q, frame_start_q;
  logic [15:0] hpos_q, vpos_q;

  logic        h_last, v_last, limit_hit;
  logic        vsync_d, hsync_d, de_d, frame_start_d;
  logic [15:0] hpos_d, vpos_d;

  assign h_last = (h_cnt_q == H_LAST);
  assign v_last = (v_cnt_q == V_LAST);
  // frame_cnt_q + 1 is the count this frame end is about to publish
  assign limit_hit = LIMIT_EN && ((frame_cnt_q + 16'd1) == NUM_FRAMES_W);

  assign hsync_d       = (h_cnt_q < H_SYNC_W);
  assign vsync_d       = (v_cnt_q < V_SYNC_W);
  assign de_d          = (h_cnt_q >= H_DE_START) && (h_cnt_q <= H_DE_END) &&
                         (v_cnt_q >= V_DE_START) && (v_cnt_q <= V_DE_END);
  assign hpos_d        = de_d ? (h_cnt_q - H_DE_START) : 16'd0;
  assign vpos_d        = de_d ? (v_cnt_q - V_DE_START) : 16'd0;
  assign frame_start_d = (h_cnt_q == 16'd0) && (v_cnt_q == 16'd0);

`ifdef VTG_FRAME_LIMIT_EN
  logic done_q;
  assign o_done = done_q;
`else
  assign o_done = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      frame_cnt_q   <= '0;
      vsync_q       <= 1'b0;
      hsync_q       <= 1'b0;
      de_q          <= 1'b0;
      hpos_q        <= '0;
      vpos_q        <= '0;
      frame_start_q <= 1'b0;
`ifdef VTG_FRAME_LIMIT_EN
      done_q        <= 1'b0;
`endif
    end else begin
      vsync_q       <= 1'b0;
      hsync_q       <= 1'b0;
      de_q          <= 1'b0;
      hpos_q        <= '0;
      vpos_q        <= '0;
      frame_start_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          h_cnt_q <= '0;
          v_cnt_q <= '0;
          if (i_en) state_q <= S_RUN;
        end
        S_RUN: begin
          vsync_q       <= vsync_d;
          hsync_q       <= hsync_d;
          de_q          <= de_d;
          hpos_q        <= hpos_d;
          vpos_q        <= vpos_d;
          frame_start_q <= frame_start_d;
          if (h_last) begin
            h_cnt_q <= '0;
            if (v_last) begin
              // frame boundary: the only place a run may stop
              v_cnt_q     <= '0;
              frame_cnt_q <= frame_cnt_q + 16'd1;
              if (limit_hit) begin
                state_q <= S_STOP;
`ifdef VTG_FRAME_LIMIT_EN
                done_q  <= 1'b1;
`endif
              end else if (!i_en) begin
                state_q <= S_IDLE;
              end
            end else begin
              v_cnt_q <= v_cnt_q + 16'd1;
            end
          end else begin
            h_cnt_q <= h_cnt_q + 16'd1;
          end
        end
        S_STOP: begin
          h_cnt_q <= '0;
          v_cnt_q <= '0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_vsync       = vsync_q;
  assign o_hsync       = hsync_q;
  assign o_de          = de_q;
  assign o_hpos        = hpos_q;
  assign o_vpos        = vpos_q;
  assign o_frame_start = frame_start_q;
  assign o_frame_cnt   = frame_cnt_q;

endmodule
